// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
// The FSM state encoding and the largest legal BCD digit value live here.
package bcd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_mac.sv
// One Horner step of the conversion: {carry, sum} = acc*10 + digit.
// The x10 is built from two shifts so no multiplier is inferred.
module bcd_digit_mac #(
    parameter int BIN_WIDTH = 32
) (
    input  logic [BIN_WIDTH-1:0] acc,
    input  logic [3:0]           digit,
    output logic [3:0]           carry,
    output logic [BIN_WIDTH-1:0] sum
);

    logic [BIN_WIDTH+3:0] wide;
    logic [BIN_WIDTH+3:0] step;

    // Four spare bits always hold 10*acc+15, so the top nibble is the exact overflow.
    assign wide = {4'b0000, acc};
    assign step = (wide << 3) + (wide << 1) + {{BIN_WIDTH{1'b0}}, digit};
    assign {carry, sum} = step;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Define BCD_TO_BIN_CHECK_EN to build the digit>9 check that drives err.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 32,
    parameter int DIGITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_WIDTH-1:0]  bin,
    output logic                  ovf,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t               state;
    state_t               state_nxt;
    logic [BCD_W-1:0]     shreg;
    logic [CNT_W-1:0]     cnt;
    logic [BIN_WIDTH-1:0] acc;
    logic [BIN_WIDTH-1:0] sum;
    logic [3:0]           carry;
    logic [3:0]           digit;

    // The captured word shifts left each step, so digit[cnt] is always the top nibble.
    assign digit = shreg[BCD_W-1 -: 4];
    assign busy  = (state == CONV);

    bcd_digit_mac #(
        .BIN_WIDTH (BIN_WIDTH)
    ) u_mac (
        .acc   (acc),
        .digit (digit),
        .carry (carry),
        .sum   (sum)
    );

    always_comb begin
        // NOTE: default first, so no path leaves state_nxt unassigned and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            acc   <= '0;
            bin   <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= bcd;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= CNT_W'(DIGITS - 1);
                    end
                end
                CONV: begin
                    shreg <= shreg << 4;
                    acc   <= sum;
                    if (carry != 4'h0) ovf <= 1'b1;
                    if (cnt == '0) begin
                        bin  <= sum;
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_TO_BIN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == IDLE && start) begin
            err <= 1'b0;
        end else if (state == CONV && digit > BCD_DIGIT_MAX) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: default 32-bit/8-digit instance plus a 16-bit/5-digit
// instance for the overflow boundary. Expected err follows BCD_TO_BIN_CHECK_EN.
module tb_bcd_to_bin;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bcd = '0;
    logic        busy, done, ovf, err;
    logic [31:0] bin;

    logic        start16 = 1'b0;
    logic [19:0] bcd16 = '0;
    logic        busy16, done16, ovf16, err16;
    logic [15:0] bin16;

    int n_vec = 0;
    int n_bad = 0;

`ifdef BCD_TO_BIN_CHECK_EN
    localparam logic ERR_ON_HEX = 1'b1;
`else
    localparam logic ERR_ON_HEX = 1'b0;
`endif

    always #5 clk = ~clk;

    bcd_to_bin #(.BIN_WIDTH(32), .DIGITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd),
        .busy(busy), .done(done), .bin(bin), .ovf(ovf), .err(err)
    );

    bcd_to_bin #(.BIN_WIDTH(16), .DIGITS(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .bcd(bcd16),
        .busy(busy16), .done(done16), .bin(bin16), .ovf(ovf16), .err(err16)
    );

    // Runs one conversion on dut; returns outputs at done, latency and busy cycle count.
    task automatic convert(input logic [31:0] v, output logic [31:0] b, output logic o,
                           output logic e, output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1;
        bcd   = v;
        @(posedge clk); #1;
        start = 1'b0;
        bcd   = 32'hDEAD_BEEF;
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 50) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        b = bin;
        o = ovf;
        e = err;
    endtask

    task automatic convert16(input logic [19:0] v, output logic [15:0] b, output logic o,
                             output int lat);
        @(negedge clk);
        start16 = 1'b1;
        bcd16   = v;
        @(posedge clk); #1;
        start16 = 1'b0;
        bcd16   = 20'hFFFFF;
        lat = 0;
        while (!done16 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        b = bin16;
        o = ovf16;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (bin !== 32'h0) begin n_bad++; $display("FAIL reset_bin got %h want 0", bin); end
        n_vec++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] b; logic o, e; int lat, bn;
        convert(32'h12345678, b, o, e, lat, bn);
        n_vec++; if (b !== 32'h00BC614E) begin n_bad++; $display("FAIL basic_bin got %h want 00bc614e", b); end
        n_vec++; if (o !== 1'b0) begin n_bad++; $display("FAIL basic_ovf got %b want 0", o); end
        n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL basic_err got %b want 0", e); end
        n_vec++; if (lat !== 8) begin n_bad++; $display("FAIL basic_latency got %0d want 8", lat); end
        n_vec++; if (bn !== 8) begin n_bad++; $display("FAIL basic_busy_cycles got %0d want 8", bn); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        @(posedge clk); #1;
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b want 0", done); end
        repeat (3) @(posedge clk); #1;
        n_vec++; if (bin !== 32'h00BC614E) begin n_bad++; $display("FAIL basic_bin_hold got %h want 00bc614e", bin); end
    endtask

    task automatic test_max();
        logic [31:0] b; logic o, e; int lat, bn;
        convert(32'h99999999, b, o, e, lat, bn);
        n_vec++; if (b !== 32'h05F5E0FF) begin n_bad++; $display("FAIL max_bin got %h want 05f5e0ff", b); end
        n_vec++; if (o !== 1'b0) begin n_bad++; $display("FAIL max_ovf got %b want 0", o); end
        convert(32'h00000000, b, o, e, lat, bn);
        n_vec++; if (b !== 32'h0) begin n_bad++; $display("FAIL zero_bin got %h want 0", b); end
    endtask

    task automatic test_overflow();
        logic [15:0] b; logic o; int lat;
        convert16(20'h65536, b, o, lat);
        n_vec++; if (b !== 16'h0000) begin n_bad++; $display("FAIL ovf16_bin got %h want 0000", b); end
        n_vec++; if (o !== 1'b1) begin n_bad++; $display("FAIL ovf16_flag got %b want 1", o); end
        n_vec++; if (lat !== 5) begin n_bad++; $display("FAIL ovf16_latency got %0d want 5", lat); end
        convert16(20'h65535, b, o, lat);
        n_vec++; if (b !== 16'hFFFF) begin n_bad++; $display("FAIL edge16_bin got %h want ffff", b); end
        n_vec++; if (o !== 1'b0) begin n_bad++; $display("FAIL edge16_ovf got %b want 0", o); end
        convert16(20'h99999, b, o, lat);
        n_vec++; if (b !== 16'h869F) begin n_bad++; $display("FAIL wrap16_bin got %h want 869f", b); end
        n_vec++; if (o !== 1'b1) begin n_bad++; $display("FAIL wrap16_ovf got %b want 1", o); end
    endtask

    task automatic test_err();
        logic [31:0] b; logic o, e; int lat, bn;
        convert(32'h0000000A, b, o, e, lat, bn);
        n_vec++; if (b !== 32'd10) begin n_bad++; $display("FAIL err_a_bin got %0d want 10", b); end
        n_vec++; if (e !== ERR_ON_HEX) begin n_bad++; $display("FAIL err_a_flag got %b want %b", e, ERR_ON_HEX); end
        convert(32'h0000001F, b, o, e, lat, bn);
        n_vec++; if (b !== 32'd25) begin n_bad++; $display("FAIL err_1f_bin got %0d want 25", b); end
        n_vec++; if (e !== ERR_ON_HEX) begin n_bad++; $display("FAIL err_1f_flag got %b want %b", e, ERR_ON_HEX); end
        convert(32'h00000042, b, o, e, lat, bn);
        n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b want 0", e); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] b; logic o, e; int lat, bn, seen;
        @(negedge clk);
        start = 1'b1;
        bcd   = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done got %b want 0", done); end
        n_vec++; if (bin !== 32'h0) begin n_bad++; $display("FAIL abort_bin got %h want 0", bin); end
        n_vec++; if (ovf !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL abort_flags got %b%b want 00", ovf, err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
        convert(32'h00000042, b, o, e, lat, bn);
        n_vec++; if (b !== 32'd42) begin n_bad++; $display("FAIL abort_restart_bin got %0d want 42", b); end
        n_vec++; if (lat !== 8) begin n_bad++; $display("FAIL abort_restart_latency got %0d want 8", lat); end
    endtask

    task automatic test_back_to_back();
        int t[4];
        int n;
        logic [31:0] bv[4];
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b1;
            bcd   = 32'h00000007;
            @(posedge clk); #1;
            if (done && n < 4) begin
                t[n]  = i;
                bv[n] = bin;
                n++;
            end
        end
        start = 1'b0;
        n_vec++;
        if (n < 3) begin
            n_bad++; $display("FAIL b2b_count got %0d want >=3", n);
        end else begin
            if (t[1] - t[0] !== 9 || t[2] - t[1] !== 9) begin
                n_bad++; $display("FAIL b2b_period got %0d,%0d want 9,9", t[1] - t[0], t[2] - t[1]);
            end
            n_vec++;
            if (bv[0] !== 32'd7 || bv[1] !== 32'd7 || bv[2] !== 32'd7) begin
                n_bad++; $display("FAIL b2b_bin got %0d,%0d,%0d want 7", bv[0], bv[1], bv[2]);
            end
        end
        for (int i = 0; i < 20 && (busy || done); i++) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got busy=%b want 0", busy); end
    endtask

    task automatic test_start_while_busy();
        int n;
        logic [31:0] b;
        n = 0;
        b = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = (i == 0 || i == 2 || i == 5);
            bcd   = (i == 0) ? 32'h00000012 : 32'h00000099;
            @(posedge clk); #1;
            if (done) begin
                n++;
                b = bin;
            end
        end
        start = 1'b0;
        n_vec++; if (n !== 1) begin n_bad++; $display("FAIL busy_ignore_count got %0d want 1", n); end
        n_vec++; if (b !== 32'd12) begin n_bad++; $display("FAIL busy_ignore_bin got %0d want 12", b); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_overflow();
        test_err();
        test_reset_abort();
        test_back_to_back();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
